modn_updown_counter: RTL and testbench

Parametrised successor to the fixed mod-N counter. The modulus is programmable at runtime. Supports up/down direction, count enable, synchronous parallel load, a registered terminal-count pulse and a wrap-event counter. Used as a general timebase/sequence counter; tc and wrap_cnt feed downstream schedulers and cascade stages.

---
 rtl/modn_updown_counter.sv | 93 +++++++++
 tb/tb_modn_updown_counter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modn_updown_counter.sv
// Programmable mod-M up/down counter with load clamp, registered terminal count and wrap-event counter.
// Optional enabled-cycle prescaler compiled in with `define MODN_CNT_PRESCALE_EN.
module modn_updown_counter #(
    parameter int WIDTH    = 8,
    parameter int WRAP_W   = 8,
    parameter int PRESCALE = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              up_dn,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic [WIDTH-1:0]  mod_val,
    output logic [WIDTH-1:0]  out,
    output logic              tc,
    output logic              load_err,
    output logic [WRAP_W-1:0] wrap_cnt
);

    logic [WIDTH:0]   m_ext;
    logic [WIDTH-1:0] m_top;
    logic             load_oor;
    logic             wrap_up;
    logic             wrap_dn;
    logic             wrap;
    logic [WIDTH-1:0] nxt_step;
    logic             presc_hit;
    logic             step;

    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v,
                                                     input logic [WIDTH:0]   m,
                                                     input logic [WIDTH-1:0] top);
        return ({1'b0, v} < m) ? v : top;
    endfunction

    // Modulus is held on WIDTH+1 bits so mod_val=0 can mean 2^WIDTH; M-1 then wraps to all-ones.
    assign m_ext    = (mod_val == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, mod_val};
    assign m_top    = mod_val - WIDTH'(1);
    assign load_oor = ({1'b0, load_val} >= m_ext);

    // Out-of-range states (out >= M after a modulus drop) wrap in either direction.
    assign wrap_up  = ({1'b0, out} >= (m_ext - (WIDTH+1)'(1)));
    assign wrap_dn  = (out == '0) || ({1'b0, out} >= m_ext);
    assign wrap     = up_dn ? wrap_up : wrap_dn;
    assign nxt_step = up_dn ? (wrap_up ? '0 : out + WIDTH'(1))
                            : (wrap_dn ? m_top : out - WIDTH'(1));

`ifdef MODN_CNT_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] presc;

    assign presc_hit = (presc == PW'(PRESCALE - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            presc <= '0;
        end else if (load) begin
            presc <= '0;
        end else if (en) begin
            presc <= presc_hit ? '0 : presc + PW'(1);
        end
    end
`else
    // PRESCALE is always >= 1, so without the prescaler every enabled cycle steps.
    assign presc_hit = (PRESCALE >= 1);
`endif

    assign step = en && !load && presc_hit;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out      <= '0;
            tc       <= 1'b0;
            load_err <= 1'b0;
            wrap_cnt <= '0;
        end else if (load) begin
            out      <= clamp_load(load_val, m_ext, m_top);
            load_err <= load_oor;
            tc       <= 1'b0;
        end else if (step) begin
            out      <= nxt_step;
            tc       <= wrap;
            load_err <= 1'b0;
            wrap_cnt <= wrap_cnt + {{(WRAP_W-1){1'b0}}, wrap};
        end else begin
            tc       <= 1'b0;
            load_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_modn_updown_counter.sv
// Randomized and directed bench for modn_updown_counter against an integer reference model.
// Honours MODN_CNT_PRESCALE_EN when the design is built with it.
module tb_modn_updown_counter;

    localparam int WIDTH    = 8;
    localparam int WRAP_W   = 8;
    localparam int PRESCALE = 4;
`ifdef MODN_CNT_PRESCALE_EN
    localparam int STEP_CYC = PRESCALE;
`else
    localparam int STEP_CYC = 1;
`endif

    logic              clk = 1'b0;
    logic              rstn;
    logic              en;
    logic              up_dn;
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic [WIDTH-1:0]  mod_val;
    logic [WIDTH-1:0]  out;
    logic              tc;
    logic              load_err;
    logic [WRAP_W-1:0] wrap_cnt;

    int m_out, m_wrap, m_ps;
    bit m_tc, m_err;
    int nvec = 0;
    int nerr = 0;

    modn_updown_counter #(.WIDTH(WIDTH), .WRAP_W(WRAP_W), .PRESCALE(PRESCALE)) dut (
        .clk(clk), .rstn(rstn), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .mod_val(mod_val), .out(out), .tc(tc),
        .load_err(load_err), .wrap_cnt(wrap_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_out = 0; m_wrap = 0; m_ps = 0; m_tc = 0; m_err = 0;
    endtask

    // Advance one clock and update the model from the inputs seen at that edge; returns 1 ns later.
    task automatic tick();
        int  mm;
        bit  stp;
        bit  w;
        @(posedge clk);
        mm = (mod_val == 0) ? (1 << WIDTH) : int'(mod_val);
        if (!rstn) begin
            model_reset();
        end else if (load) begin
            m_ps = 0;
            m_tc = 0;
            if (int'(load_val) < mm) begin
                m_out = int'(load_val); m_err = 0;
            end else begin
                m_out = mm - 1; m_err = 1;
            end
        end else if (en) begin
            m_err = 0;
            m_tc  = 0;
`ifdef MODN_CNT_PRESCALE_EN
            stp = (m_ps == PRESCALE - 1);
            m_ps = stp ? 0 : m_ps + 1;
`else
            stp = 1;
`endif
            if (stp) begin
                if (up_dn) begin
                    w = (m_out + 1 >= mm);
                    m_out = w ? 0 : m_out + 1;
                end else begin
                    w = (m_out == 0) || (m_out >= mm);
                    m_out = w ? mm - 1 : m_out - 1;
                end
                if (w) begin
                    m_tc = 1;
                    m_wrap = (m_wrap + 1) % (1 << WRAP_W);
                end
            end
        end else begin
            m_tc = 0; m_err = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; en = 0; up_dn = 1; load = 0; load_val = '0; mod_val = 8'd10;
        model_reset();
        #12;
        nvec++;
        if (out !== 8'd0 || tc !== 1'b0 || load_err !== 1'b0 || wrap_cnt !== 8'd0) begin
            nerr++;
            $display("FAIL reset: got out=%0d tc=%0b err=%0b wrap=%0d, want all 0", out, tc, load_err, wrap_cnt);
        end
        rstn = 1'b1;
    endtask

    task automatic test_up_count();
        mod_val = 8'd10; up_dn = 1; en = 1; load = 0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            nvec++;
            if (out !== WIDTH'(m_out) || tc !== m_tc || load_err !== m_err || wrap_cnt !== WRAP_W'(m_wrap)) begin
                nerr++;
                $display("FAIL up_count k=%0d: got out=%0d tc=%0b err=%0b wrap=%0d, want %0d %0b %0b %0d",
                         k, out, tc, load_err, wrap_cnt, m_out, m_tc, m_err, m_wrap);
            end
`ifndef MODN_CNT_PRESCALE_EN
            nvec++;
            if (out !== WIDTH'(k % 10) || tc !== (k % 10 == 0)) begin
                nerr++;
                $display("FAIL up_seq k=%0d: got out=%0d tc=%0b, want out=%0d tc=%0b", k, out, tc, k % 10, k % 10 == 0);
            end
`endif
        end
`ifndef MODN_CNT_PRESCALE_EN
        nvec++;
        if (wrap_cnt !== 8'd2) begin
            nerr++;
            $display("FAIL up_wraps: got wrap_cnt=%0d, want 2", wrap_cnt);
        end
`endif
    endtask

    task automatic test_down_count();
        mod_val = 8'd5; load = 1; load_val = 8'd0; en = 0;
        tick();
        load = 0; up_dn = 0; en = 1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            nvec++;
            if (out !== WIDTH'(m_out) || tc !== m_tc || load_err !== m_err || wrap_cnt !== WRAP_W'(m_wrap)) begin
                nerr++;
                $display("FAIL down_count k=%0d: got out=%0d tc=%0b err=%0b wrap=%0d, want %0d %0b %0b %0d",
                         k, out, tc, load_err, wrap_cnt, m_out, m_tc, m_err, m_wrap);
            end
`ifndef MODN_CNT_PRESCALE_EN
            nvec++;
            if (out !== WIDTH'((5 - k % 5) % 5) || tc !== (k % 5 == 1)) begin
                nerr++;
                $display("FAIL down_seq k=%0d: got out=%0d tc=%0b, want out=%0d tc=%0b", k, out, tc, (5 - k % 5) % 5, k % 5 == 1);
            end
`endif
        end
    endtask

    task automatic test_load();
        mod_val = 8'd10; up_dn = 1; en = 1; load = 1; load_val = 8'd7;
        tick();
        nvec++;
        if (out !== 8'd7 || load_err !== 1'b0 || tc !== 1'b0 || out !== WIDTH'(m_out)) begin
            nerr++;
            $display("FAIL load_in_range: got out=%0d err=%0b tc=%0b, want out=7 err=0 tc=0", out, load_err, tc);
        end
        load_val = 8'd12;
        tick();
        nvec++;
        if (out !== 8'd9 || load_err !== 1'b1 || load_err !== m_err) begin
            nerr++;
            $display("FAIL load_clamp: got out=%0d err=%0b, want out=9 err=1", out, load_err);
        end
        load = 0; en = 0;
        tick();
        nvec++;
        if (out !== 8'd9 || load_err !== 1'b0 || tc !== 1'b0) begin
            nerr++;
            $display("FAIL load_err_pulse: got out=%0d err=%0b tc=%0b, want out=9 err=0 tc=0", out, load_err, tc);
        end
    endtask

    task automatic test_mod_change();
        mod_val = 8'd10; load = 1; load_val = 8'd8; en = 0; up_dn = 1;
        tick();
        load = 0; mod_val = 8'd6; en = 1;
        for (int k = 0; k < STEP_CYC; k++) tick();
        nvec++;
        if (out !== 8'd0 || tc !== 1'b1 || out !== WIDTH'(m_out) || wrap_cnt !== WRAP_W'(m_wrap)) begin
            nerr++;
            $display("FAIL mod_drop: got out=%0d tc=%0b wrap=%0d, want out=0 tc=1 wrap=%0d", out, tc, wrap_cnt, m_wrap);
        end
        mod_val = 8'd0; load = 1; load_val = 8'd254;
        tick();
        load = 0;
        for (int k = 0; k < STEP_CYC; k++) tick();
        nvec++;
        if (out !== 8'd255 || tc !== 1'b0) begin
            nerr++;
            $display("FAIL full_range_255: got out=%0d tc=%0b, want out=255 tc=0", out, tc);
        end
        for (int k = 0; k < STEP_CYC; k++) tick();
        nvec++;
        if (out !== 8'd0 || tc !== 1'b1 || wrap_cnt !== WRAP_W'(m_wrap)) begin
            nerr++;
            $display("FAIL full_range_wrap: got out=%0d tc=%0b wrap=%0d, want out=0 tc=1 wrap=%0d", out, tc, wrap_cnt, m_wrap);
        end
    endtask

    task automatic test_async_reset();
        mod_val = 8'd10; up_dn = 1; en = 0; load = 1; load_val = 8'd6;
        tick();
        load = 0; en = 1;
        #3;
        rstn = 1'b0;
        model_reset();
        #1;
        nvec++;
        if (out !== 8'd0 || tc !== 1'b0 || load_err !== 1'b0 || wrap_cnt !== 8'd0) begin
            nerr++;
            $display("FAIL async_reset: got out=%0d tc=%0b err=%0b wrap=%0d, want all 0", out, tc, load_err, wrap_cnt);
        end
        tick();
        nvec++;
        if (out !== 8'd0 || wrap_cnt !== 8'd0) begin
            nerr++;
            $display("FAIL reset_held: got out=%0d wrap=%0d, want 0 0", out, wrap_cnt);
        end
        #3;
        rstn = 1'b1;
        for (int k = 0; k < STEP_CYC; k++) tick();
        nvec++;
        if (out !== 8'd1 || tc !== 1'b0 || wrap_cnt !== 8'd0 || out !== WIDTH'(m_out)) begin
            nerr++;
            $display("FAIL resume: got out=%0d tc=%0b wrap=%0d, want out=1 tc=0 wrap=0", out, tc, wrap_cnt);
        end
    endtask

`ifdef MODN_CNT_PRESCALE_EN
    task automatic test_prescale();
        mod_val = 8'd3; up_dn = 1; en = 0; load = 1; load_val = 8'd0;
        tick();
        load = 0; en = 1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            nvec++;
            if (out !== WIDTH'((k / 4) % 3) || out !== WIDTH'(m_out) || tc !== m_tc) begin
                nerr++;
                $display("FAIL prescale k=%0d: got out=%0d tc=%0b, want out=%0d tc=%0b", k, out, tc, (k / 4) % 3, m_tc);
            end
        end
        tick(); tick();
        en = 0;
        tick(); tick(); tick();
        en = 1;
        tick();
        nvec++;
        if (out !== 8'd0) begin
            nerr++;
            $display("FAIL prescale_hold: got out=%0d, want 0", out);
        end
        tick();
        nvec++;
        if (out !== 8'd1 || out !== WIDTH'(m_out)) begin
            nerr++;
            $display("FAIL prescale_delay: got out=%0d, want 1", out);
        end
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            if (k % 40 == 0) begin
                case ($urandom % 5)
                    0: mod_val = 8'd0;
                    1: mod_val = 8'd1;
                    2: mod_val = 8'd2;
                    3: mod_val = WIDTH'($urandom_range(3, 12));
                    default: mod_val = WIDTH'($urandom);
                endcase
            end
            load     = ($urandom % 16 == 0);
            load_val = WIDTH'($urandom);
            en       = ($urandom % 4 != 0);
            up_dn    = $urandom % 2;
            tick();
            nvec++;
            if (out !== WIDTH'(m_out) || tc !== m_tc || load_err !== m_err || wrap_cnt !== WRAP_W'(m_wrap)) begin
                nerr++;
                $display("FAIL random k=%0d mod=%0d: got out=%0d tc=%0b err=%0b wrap=%0d, want %0d %0b %0b %0d",
                         k, mod_val, out, tc, load_err, wrap_cnt, m_out, m_tc, m_err, m_wrap);
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_down_count();
        test_load();
        test_mod_change();
        test_async_reset();
`ifdef MODN_CNT_PRESCALE_EN
        test_prescale();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
